// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and its consumers.
//   state_e       : loader FSM states
//   SyncByteDefault: default frame start marker
//   BytesPerWord  : payload bytes per instruction word (little-endian)
//   NFieldW       : width of the frame word-count field
//   instr_word_t  : 32-bit instruction word, shared with the CPU
package prog_loader_pkg;

  typedef enum logic [1:0] {StIdle, StCount, StData, StCheck} state_e;

  localparam logic [7:0]  SyncByteDefault = 8'hA5;
  localparam int unsigned BytesPerWord    = 4;
  localparam int unsigned NFieldW         = 8;

  typedef logic [31:0] instr_word_t;

endpackage

// File: rtl/prog_loader_word_packer.sv
// word_packer: assembles little-endian bytes into 32-bit words and keeps a running XOR.
// Ports:
//   CLK, RST    : clock, synchronous active-high reset
//   load, seed  : restart packing at byte 0 and load the running XOR with seed
//   byte_valid  : byte_data holds a payload byte this cycle
//   byte_data   : payload byte
//   word_last   : combinational, this byte completes a word
//   word        : last completed word (registered)
//   word_valid  : one-cycle pulse the cycle after a word completes
//   xor_sum     : running XOR of seed and all payload bytes since load
module word_packer
  import prog_loader_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  logic [7:0]  seed,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_last,
  output instr_word_t word,
  output logic        word_valid,
  output logic [7:0]  xor_sum
);

  logic [1:0]  idx_q;
  logic [23:0] buf_q;  // bytes 0..2; byte 3 goes straight into the output word

  assign word_last = byte_valid && (idx_q == 2'(BytesPerWord - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q      <= '0;
      buf_q      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      xor_sum    <= '0;
    end else begin
      word_valid <= 1'b0;
      if (load) begin
        idx_q   <= '0;
        xor_sum <= seed;
      end else if (byte_valid) begin
        xor_sum <= xor_sum ^ byte_data;
        idx_q   <= idx_q + 2'd1;
        unique case (idx_q)
          2'd0: buf_q[7:0]   <= byte_data;
          2'd1: buf_q[15:8]  <= byte_data;
          2'd2: buf_q[23:16] <= byte_data;
          2'd3: begin
            word       <= {byte_data, buf_q};
            word_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: writes a framed program image from a UART byte stream into instruction memory.
// Frame: SYNC_BYTE, N (1..DEPTH), 4*N little-endian payload bytes, CHK (XOR of N and payload).
// The CPU is held until a complete image passes its checksum.
// Optional macro PROG_LOADER_TIMEOUT_EN adds an inter-byte timeout of TIMEOUT_CYCLES.
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   rx_valid, rx_data   : received byte strobe and data, no backpressure
//   mem_we, mem_addr,
//   mem_wdata           : instruction memory write port (one-cycle write pulse)
//   cpu_hold            : freezes the CPU while 1
//   load_done, load_err : level status of the last load
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter logic [7:0]  SYNC_BYTE = SyncByteDefault
`ifdef PROG_LOADER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1048575
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output instr_word_t       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  state_e             state_q;
  logic [NFieldW-1:0] n_q;
  logic [NFieldW-1:0] word_cnt_q;

  logic       n_ok;
  logic       pk_load;
  logic [7:0] pk_seed;
  logic       word_last;
  logic [7:0] chk_sum;

  assign n_ok = (rx_data != '0) && ({24'd0, rx_data} <= DEPTH);

  // Sync in IDLE clears the checksum; a good N seeds it with N.
  always_comb begin
    pk_load = 1'b0;
    pk_seed = '0;
    if (rx_valid) begin
      if (state_q == StIdle && rx_data == SYNC_BYTE) begin
        pk_load = 1'b1;
      end else if (state_q == StCount && n_ok) begin
        pk_load = 1'b1;
        pk_seed = rx_data;
      end
    end
  end

  word_packer u_packer (
    .CLK        (CLK),
    .RST        (RST),
    .load       (pk_load),
    .seed       (pk_seed),
    .byte_valid (rx_valid && (state_q == StData)),
    .byte_data  (rx_data),
    .word_last  (word_last),
    .word       (mem_wdata),
    .word_valid (mem_we),
    .xor_sum    (chk_sum)
  );

`ifdef PROG_LOADER_TIMEOUT_EN
  logic [31:0] tmo_q;
  logic        timeout_hit;

  // Fires on the TIMEOUT_CYCLES-th edge after the last accepted byte.
  assign timeout_hit = (state_q != StIdle) && (tmo_q == TIMEOUT_CYCLES - 1);

  always_ff @(posedge CLK) begin
    if (RST || rx_valid || state_q == StIdle || timeout_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 32'd1;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      n_q        <= '0;
      word_cnt_q <= '0;
      mem_addr   <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else if (rx_valid) begin
      unique case (state_q)
        StIdle: begin
          if (rx_data == SYNC_BYTE) begin
            state_q    <= StCount;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            word_cnt_q <= '0;
            mem_addr   <= '0;
          end
        end
        StCount: begin
          if (n_ok) begin
            n_q     <= rx_data;
            state_q <= StData;
          end else begin
            load_err <= 1'b1;
            state_q  <= StIdle;
          end
        end
        StData: begin
          // The packer registers the word, so mem_addr is set alongside it.
          if (word_last) begin
            mem_addr   <= word_cnt_q[ADDR_W-1:0];
            word_cnt_q <= word_cnt_q + NFieldW'(1);
            if (word_cnt_q + NFieldW'(1) == n_q) state_q <= StCheck;
          end
        end
        StCheck: begin
          if (rx_data == chk_sum) begin
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
          end else begin
            load_err <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
`ifdef PROG_LOADER_TIMEOUT_EN
    else if (timeout_hit) begin
      load_err <= 1'b1;
      state_q  <= StIdle;
    end
`endif
  end

endmodule
